// File: rtl/spi_lcd_pkg.sv
// spi_lcd_pkg: shared FSM states, panel command bytes and default timing for the LCD SPI path
package spi_lcd_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_HOLD, ST_DELAY} state_t;
  localparam logic [7:0] SWRESET = 8'h01;
  localparam logic [7:0] SLPOUT = 8'h11;
  localparam logic [7:0] DISPON = 8'h29;
  localparam logic [7:0] SET_COLUMN = 8'h2A;
  localparam logic [7:0] SET_PAGE = 8'h2B;
  localparam logic [7:0] WRITE_RAM = 8'h2C;
  localparam int CLK_DIV_DEF = 2;
  localparam int DELAY_DEF = 2_700_000;
  localparam int DELAY_W_DEF = 22;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: SCK half-period tick generator, restarted at each byte start
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt;
  assign o_tick = cnt == CW'(CLK_DIV - 1);
  always_ff @(posedge i_clk)
    if (i_rst || i_restart || o_tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/spi_byte_tx.sv
// spi_byte_tx: mode-0 MSB-first SPI byte transmitter with optional post-byte delay; SPI_TX_CS_KEEP_EN holds cs low across same-dc back-to-back bytes
module spi_byte_tx
  import spi_lcd_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int DELAY = DELAY_DEF,
  parameter int DELAY_W = DELAY_W_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_we,
  input  logic [7:0] i_byte,
  input  logic       i_dc,
  input  logic       i_need_delay,
  output logic       o_ready,
  output logic       o_done,
  output logic       o_sck,
  output logic       o_mosi,
  output logic       o_cs,
  output logic       o_dc
);
`ifdef SPI_TX_CS_KEEP_EN
  localparam bit KEEP = 1'b1;
`else
  localparam bit KEEP = 1'b0;
`endif
  localparam bit HAS_DLY = DELAY > 0;
  state_t state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] sh, sh_n;
  logic [DELAY_W-1:0] dly, dly_n;
  logic dc_l, dc_l_n, nd, nd_n, pend;
  logic ready_n, done_n, sck_n, mosi_n, cs_n, dc_n;
  logic tick, acc, gap, start, dly_go;
  assign acc = state == ST_IDLE && o_ready && i_we;
  assign gap = KEEP && acc && !o_cs && i_dc != o_dc;
  assign start = (acc && !gap) || pend;
  assign dly_go = HAS_DLY && nd;
  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_restart(start),
    .o_tick(tick)
  );
  always_comb begin
    sh_n = acc ? i_byte : sh;
    dc_l_n = acc ? i_dc : dc_l;
    nd_n = acc ? i_need_delay : nd;
    dly_n = dly;
    bit_cnt_n = bit_cnt;
    state_n = state;
    ready_n = 1'b0;
    done_n = 1'b0;
    sck_n = o_sck;
    mosi_n = o_mosi;
    cs_n = o_cs;
    dc_n = o_dc;
    case (state)
      ST_IDLE: begin
        cs_n = !start;
        ready_n = !(start || gap);
        if (start) begin
          state_n = ST_SHIFT;
          bit_cnt_n = 3'd7;
          sck_n = 1'b0;
          mosi_n = sh_n[7];
          dc_n = dc_l_n;
        end
      end
      ST_SHIFT: if (tick) begin
        sck_n = !o_sck;
        if (o_sck && bit_cnt == 3'd0) state_n = ST_HOLD;
        else if (o_sck) begin
          bit_cnt_n = bit_cnt - 3'd1;
          sh_n = {sh[6:0], 1'b0};
          mosi_n = sh[6];
        end
      end
      ST_HOLD: if (tick) begin
        mosi_n = 1'b0;
        cs_n = !KEEP || dly_go;
        state_n = dly_go ? ST_DELAY : ST_IDLE;
        ready_n = !dly_go;
        done_n = !dly_go;
        dly_n = '0;
      end
      ST_DELAY: if (dly == DELAY_W'(DELAY - 1)) begin
        state_n = ST_IDLE;
        ready_n = 1'b1;
        done_n = 1'b1;
      end else dly_n = dly + 1'b1;
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= ST_IDLE;
      bit_cnt <= '0;
      sh <= '0;
      dly <= '0;
      dc_l <= 1'b0;
      nd <= 1'b0;
      pend <= 1'b0;
      o_ready <= 1'b1;
      o_done <= 1'b0;
      o_sck <= 1'b0;
      o_mosi <= 1'b0;
      o_cs <= 1'b1;
      o_dc <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      sh <= sh_n;
      dly <= dly_n;
      dc_l <= dc_l_n;
      nd <= nd_n;
      pend <= gap;
      o_ready <= ready_n;
      o_done <= done_n;
      o_sck <= sck_n;
      o_mosi <= mosi_n;
      o_cs <= cs_n;
      o_dc <= dc_n;
    end
endmodule
